// File: rtl/cam_pkg.sv
// Shared timing defaults, FSM encoding and RGB444 byte-packing helpers for the
// camera pattern transmitter.
package cam_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_TOTAL  = 1568;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BACK   = 17;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_AW       = 19;

    localparam int PIX_W  = 12;
    localparam int BYTE_W = 8;
    localparam int R_LSB  = 8;
    localparam int G_LSB  = 4;
    localparam int B_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } cam_state_t;

    // Even byte carries red in the low nibble, odd byte carries {G,B}.
    function automatic logic [BYTE_W-1:0] pack_byte(input logic [PIX_W-1:0] pix,
                                                    input logic odd);
        logic [BYTE_W-1:0] b;
        if (odd)
            b = {pix[G_LSB+3:G_LSB], pix[B_LSB+3:B_LSB]};
        else
            b = {4'b0000, pix[R_LSB+3:R_LSB]};
        return b;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/cam_line_timer.sv
// Horizontal/vertical position counters for the pattern transmitter; flags the
// last cycle of a line, the last line of the current block and the href window.
module cam_line_timer #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 1568,
    parameter int HW       = 11,
    parameter int VW       = 9
) (
    input  logic          i_pclk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_run,
    input  logic [VW-1:0] i_v_lines,
    output logic [HW-1:0] h_cnt,
    output logic          line_end,
    output logic          block_end,
    output logic          href_window
);

    logic [VW-1:0] v_cnt;

    assign line_end    = i_run && (h_cnt == HW'(H_TOTAL - 1));
    assign block_end   = line_end && (v_cnt == i_v_lines - VW'(1));
    assign href_window = (h_cnt < HW'(2 * H_ACTIVE));

    // v_cnt counts lines inside the current vertical block and restarts per block.
    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_clear) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_run) begin
            if (line_end) begin
                h_cnt <= '0;
                if (block_end)
                    v_cnt <= '0;
                else
                    v_cnt <= v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

endmodule

// File: rtl/cam_pattern_tx.sv
// Camera emulator: replays an RGB444 frame buffer as an OV7670-style DVP stream
// (vsync/href/8-bit data, two bytes per pixel).
module cam_pattern_tx
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int AW       = DEF_AW
) (
    input  logic          i_pclk,
    input  logic          i_rst,
    input  logic          i_enable,
    output logic [AW-1:0] o_rd_addr,
    input  logic [11:0]   i_pix_data,
    output logic          o_vsync,
    output logic          o_href,
    output logic [7:0]    o_D,
    output logic          o_frame_done,
    output logic          o_busy
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(max4(V_SYNC, V_BACK, V_ACTIVE, V_FRONT) + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(H_ACTIVE * V_ACTIVE - 1);

    cam_state_t    state;
    cam_state_t    state_nxt;
    logic          start;
    logic          run;
    logic [VW-1:0] v_lines;
    logic [HW-1:0] h_cnt;
    logic          line_end;
    logic          block_end;
    logic          href_window;
    logic          frame_end;
    logic          load_inline;
    logic          load_line;
    logic          load;
    logic          active_byte;
    logic [AW-1:0] rd_addr;
    logic [11:0]   pix_reg;

    assign run = (state != ST_IDLE);

    cam_line_timer #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .HW       (HW),
        .VW       (VW)
    ) u_timer (
        .i_pclk      (i_pclk),
        .i_rst       (i_rst),
        .i_clear     (start),
        .i_run       (run),
        .i_v_lines   (v_lines),
        .h_cnt       (h_cnt),
        .line_end    (line_end),
        .block_end   (block_end),
        .href_window (href_window)
    );

    always_comb begin
        v_lines = VW'(1);
        case (state)
            ST_VSYNC:  v_lines = VW'(V_SYNC);
            ST_VBACK:  v_lines = VW'(V_BACK);
            ST_ACTIVE: v_lines = VW'(V_ACTIVE);
            ST_VFRONT: v_lines = VW'(V_FRONT);
            default:   v_lines = VW'(1);
        endcase
    end

    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // i_enable only matters in IDLE and on the final VFRONT cycle, so frames never truncate.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_enable) begin
                    state_nxt = ST_VSYNC;
                    start     = 1'b1;
                end
            end
            ST_VSYNC:  if (block_end) state_nxt = ST_VBACK;
            ST_VBACK:  if (block_end) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (block_end) state_nxt = ST_VFRONT;
            ST_VFRONT: begin
                if (block_end) begin
                    if (i_enable) begin
                        state_nxt = ST_VSYNC;
                        start     = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign frame_end = (state == ST_VFRONT) && block_end;

    // Pixel j+1 is latched on the odd byte of pixel j; a line's first pixel on the
    // last blanking cycle of the line before it.
    assign load_inline = (state == ST_ACTIVE) && h_cnt[0] &&
                         (h_cnt < HW'(2 * H_ACTIVE - 2));
    assign load_line   = line_end &&
                         (((state == ST_VBACK) && block_end) ||
                          ((state == ST_ACTIVE) && !block_end));
    assign load        = load_inline || load_line;

    // The address always points at the next pixel to latch and parks on the last one.
    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            rd_addr <= '0;
            pix_reg <= '0;
        end else begin
            if (start)
                rd_addr <= '0;
            else if (load && (rd_addr != LAST_ADDR))
                rd_addr <= rd_addr + AW'(1);
            if (load)
                pix_reg <= i_pix_data;
        end
    end

    assign o_rd_addr   = rd_addr;
    assign active_byte = (state == ST_ACTIVE) && href_window;

    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            o_vsync      <= 1'b0;
            o_href       <= 1'b0;
            o_D          <= '0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_vsync      <= (state == ST_VSYNC);
            o_href       <= active_byte;
            o_D          <= active_byte ? pack_byte(pix_reg, h_cnt[0]) : 8'h00;
            o_frame_done <= frame_end;
            o_busy       <= run;
        end
    end

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Self-checking bench for cam_pattern_tx using a small frame geometry and a
// frame-level reference model of the expected DVP stream.
module tb_cam_pattern_tx;

    localparam int HA    = 4;
    localparam int HT    = 12;
    localparam int VS    = 1;
    localparam int VB    = 1;
    localparam int VA    = 2;
    localparam int VF    = 1;
    localparam int AW    = 19;
    localparam int NPIX  = HA * VA;
    localparam int FRAME = (VS + VB + VA + VF) * HT;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [AW-1:0] rd_addr;
    logic [11:0]   pix_data;
    logic          vsync;
    logic          href;
    logic [7:0]    d_out;
    logic          frame_done;
    logic          busy;

    logic [11:0]   mem [NPIX];
    logic [AW-1:0] max_addr;
    int            cyc;
    int            n_checks;
    int            n_fail;
    int            rise_cyc;
    int            prev_rise;
    int            en_cyc;

    cam_pattern_tx #(
        .H_ACTIVE (HA),
        .H_TOTAL  (HT),
        .V_SYNC   (VS),
        .V_BACK   (VB),
        .V_ACTIVE (VA),
        .V_FRONT  (VF),
        .AW       (AW)
    ) dut (
        .i_pclk       (clk),
        .i_rst        (rst),
        .i_enable     (enable),
        .o_rd_addr    (rd_addr),
        .i_pix_data   (pix_data),
        .o_vsync      (vsync),
        .o_href       (href),
        .o_D          (d_out),
        .o_frame_done (frame_done),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle synchronous-read frame buffer plus a record of the highest address seen.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        pix_data <= (rd_addr < AW'(NPIX)) ? mem[rd_addr[2:0]] : 12'hFFF;
        if (rd_addr > max_addr)
            max_addr <= rd_addr;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {vsync, href, D, frame_done, busy} at offset t from the vsync rise.
    function automatic logic [11:0] expected_at(input int t);
        int line;
        int col;
        int k;
        logic vs;
        logic hr;
        logic fd;
        logic [7:0] b;
        logic [11:0] px;
        line = t / HT;
        col  = t % HT;
        vs   = (line < VS);
        hr   = (line >= VS + VB) && (line < VS + VB + VA) && (col < 2 * HA);
        fd   = (t == FRAME - 1);
        b    = 8'h00;
        if (hr) begin
            k  = (line - VS - VB) * HA + col / 2;
            px = mem[k];
            if (col % 2 == 1)
                b = px[7:0];
            else
                b = {4'h0, px[11:8]};
        end
        return {vs, hr, b, fd, 1'b1};
    endfunction

    task automatic wait_vsync_rise(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (vsync === 1'b1)
                found = 1'b1;
        end
    endtask

    task automatic apply_random_image();
        for (int k = 0; k < NPIX; k++)
            mem[k] = 12'($urandom);
    endtask

    // Checks one full frame cycle by cycle; optionally drops enable at offset drop_at.
    task automatic check_frame(input int drop_at);
        bit found;
        wait_vsync_rise(found);
        check_output("vsync_rise_seen", {31'b0, found}, 32'd1);
        if (!found)
            return;
        prev_rise = rise_cyc;
        rise_cyc  = cyc;
        check_output("addr_at_frame_start", rd_addr, 32'd0);
        for (int t = 0; t < FRAME; t++) begin
            if (t > 0)
                @(negedge clk);
            if (t == drop_at)
                enable = 1'b0;
            check_output($sformatf("stream t=%0d", t),
                         {vsync, href, d_out, frame_done, busy}, expected_at(t));
        end
    endtask

    task automatic check_quiet(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_output(tag, {vsync, href, d_out, frame_done, busy}, 32'd0);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rise_cyc  = -1;
        prev_rise = -1;
        max_addr  = '0;
        enable    = 1'b0;
        rst       = 1'b1;
        for (int k = 0; k < NPIX; k++)
            mem[k] = 12'(k + 'h100);

        repeat (3) @(negedge clk);
        check_output("in_reset_outputs", {vsync, href, d_out, frame_done, busy}, 32'd0);
        check_output("in_reset_addr", rd_addr, 32'd0);
        rst = 1'b0;

        // Idle with enable low: everything quiet, address parked at 0.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_output("idle_outputs", {vsync, href, d_out, frame_done, busy}, 32'd0);
            check_output("idle_addr", rd_addr, 32'd0);
        end

        // Single frame of the addr+0x100 image; enable dropped right after vsync rises.
        enable = 1'b1;
        en_cyc = cyc;
        check_frame(0);
        check_output("enable_to_vsync_latency", rise_cyc - en_cyc, 32'd2);
        check_quiet(30, "idle_after_single_frame");

        // Back-to-back frames with fresh random images, enable dropped mid-ACTIVE in the last.
        apply_random_image();
        enable = 1'b1;
        check_frame(-1);
        apply_random_image();
        check_frame(-1);
        check_output("frame_period_1", rise_cyc - prev_rise, FRAME);
        apply_random_image();
        check_frame((VS + VB) * HT + 6);
        check_output("frame_period_2", rise_cyc - prev_rise, FRAME);
        check_quiet(40, "idle_after_drop");
        check_output("max_read_addr", max_addr, NPIX - 1);

        // Reset in the middle of an active line, then a clean frame from pixel 0.
        apply_random_image();
        enable = 1'b1;
        begin
            bit found;
            wait_vsync_rise(found);
            check_output("pre_reset_vsync_seen", {31'b0, found}, 32'd1);
        end
        repeat ((VS + VB + 1) * HT + 3) @(negedge clk);
        check_output("pre_reset_href", {31'b0, href}, 32'd1);
        rst = 1'b1;
        #1;
        check_output("mid_reset_outputs", {vsync, href, d_out, frame_done, busy}, 32'd0);
        check_output("mid_reset_addr", rd_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply_random_image();
        check_frame(FRAME - 2);
        check_quiet(20, "idle_after_reset_frame");
        check_output("final_max_read_addr", max_addr, NPIX - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
